// File: rtl/immediate_splitter.sv
// Splits a 32-bit constant into the fewest 6-bit immediate chunks, MSB chunk first.
// The receiver sign-extends the first chunk, then shifts left by 6 and ORs in each later chunk.
module immediate_splitter (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_chunk,
    output logic        out_first,
    output logic        out_last,
    output logic [2:0]  out_count
);

    typedef enum logic {StIdle, StEmit} state_e;

    state_e      state_q, state_d;
    logic [31:0] value_q, value_d;
    logic [2:0]  index_q, index_d;
    logic [2:0]  count_q, count_d;
    logic [2:0]  n_calc;

    // Fewest chunks whose sign extension reproduces the value: the bits from the
    // top chunk's sign position upward must all be equal.
    always_comb begin
        if (&in_value[31:5] || ~|in_value[31:5]) begin
            n_calc = 3'd1;
        end else if (&in_value[31:11] || ~|in_value[31:11]) begin
            n_calc = 3'd2;
        end else if (&in_value[31:17] || ~|in_value[31:17]) begin
            n_calc = 3'd3;
        end else if (&in_value[31:23] || ~|in_value[31:23]) begin
            n_calc = 3'd4;
        end else if (&in_value[31:29] || ~|in_value[31:29]) begin
            n_calc = 3'd5;
        end else begin
            n_calc = 3'd6;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            value_q <= '0;
            index_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            index_q <= index_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        index_d = index_q;
        count_d = count_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StEmit;
                    value_d = in_value;
                    index_d = n_calc - 3'd1;
                    count_d = n_calc;
                end
            end
            StEmit: begin
                if (out_ready) begin
                    if (index_q == 3'd0) begin
                        state_d = StIdle;
                    end else begin
                        index_d = index_q - 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_chunk = '0;
        out_first = 1'b0;
        out_last  = 1'b0;
        out_count = count_q;
        case (state_q)
            StIdle: in_ready = 1'b1;
            StEmit: begin
                out_valid = 1'b1;
                out_first = (index_q == count_q - 3'd1);
                out_last  = (index_q == 3'd0);
                case (index_q)
                    3'd0:    out_chunk = value_q[5:0];
                    3'd1:    out_chunk = value_q[11:6];
                    3'd2:    out_chunk = value_q[17:12];
                    3'd3:    out_chunk = value_q[23:18];
                    3'd4:    out_chunk = value_q[29:24];
                    3'd5:    out_chunk = {{5{value_q[31]}}, value_q[30]};
                    default: out_chunk = '0;
                endcase
            end
            default: in_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_immediate_splitter.sv
// Directed and random checks of immediate_splitter: chunk values, flags, count,
// backpressure, reset mid-emission and reconstruction.
module tb_immediate_splitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_chunk;
    logic        out_first;
    logic        out_last;
    logic [2:0]  out_count;

    int n_pass = 0;
    int n_total = 0;

    immediate_splitter dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chunk (out_chunk),
        .out_first (out_first),
        .out_last  (out_last),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      value;
        int               n;
        logic [5:0][5:0]  ch;    // ch[0] is the first emitted chunk
        int               mode;  // 0 always ready, 1 stall 3 cycles on chunk 1
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] v, input int n, input logic [5:0] c0,
                                input logic [5:0] c1, input logic [5:0] c2, input logic [5:0] c3,
                                input logic [5:0] c4, input logic [5:0] c5, input int mode);
        vec_t r;
        r.value = v;
        r.n     = n;
        r.ch[0] = c0; r.ch[1] = c1; r.ch[2] = c2;
        r.ch[3] = c3; r.ch[4] = c4; r.ch[5] = c5;
        r.mode  = mode;
        return r;
    endfunction

    function automatic int model_n(input logic [31:0] v);
        logic signed [31:0] s;
        for (int k = 1; k <= 5; k++) begin
            s = $signed(v) >>> (6 * k - 1);
            if (s == 0 || s == -1) return k;
        end
        return 6;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Offers v, then consumes chunks; mode 2 drives out_ready randomly.
    task automatic run_value(input logic [31:0] v, input int exp_n, input logic [5:0][5:0] exp_ch,
                             input bit tab, input int mode);
        int          j = 0;
        int          stall = 0;
        int          cyc = 0;
        bit          done = 0;
        bit          r;
        logic [31:0] acc = '0;
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_value  = v;
        out_ready = 1'b0;
        @(negedge clk);
        // Competing input while emitting must be ignored
        in_valid = (mode == 1);
        in_value = ~v;
        while (!done && cyc < 100) begin
            cyc++;
            chk("out_valid", {31'd0, out_valid}, 32'd1);
            chk("in_ready_emit", {31'd0, in_ready}, 32'd0);
            chk("out_first", {31'd0, out_first}, {31'd0, (j == 0)});
            chk("out_last", {31'd0, out_last}, {31'd0, (j == exp_n - 1)});
            chk("out_count", {29'd0, out_count}, exp_n);
            if (tab) chk("out_chunk", {26'd0, out_chunk}, {26'd0, exp_ch[j]});
            case (mode)
                1:       r = !(j == 1 && stall < 3);
                2:       r = 1'($urandom_range(0, 1));
                default: r = 1'b1;
            endcase
            if (!r) stall++;
            out_ready = r;
            if (r) begin
                if (j == 0) acc = {{26{out_chunk[5]}}, out_chunk};
                else        acc = (acc << 6) | {26'd0, out_chunk};
                j++;
                if (j == exp_n) done = 1;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (!done) chk("emit_timeout", 32'd0, 32'd1);
        chk("out_valid_after", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("count_hold", {29'd0, out_count}, exp_n);
        chk("rebuild", acc, v);
    endtask

    initial begin
        logic [5:0][5:0] none;
        logic [31:0]     rv;
        none = '0;
        reset = 1'b1; in_valid = 1'b0; in_value = '0; out_ready = 1'b0;
        vecs.push_back(mk(32'h0000_0002, 1, 6'b000010, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'hFFFF_FFE2, 1, 6'b100010, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h0000_001A, 1, 6'b011010, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0020, 2, 6'b000000, 6'b100000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h8000_0000, 6, 6'b111110, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'hFFFF_FFFF, 1, 6'b111111, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h0001_2345, 3, 6'b010010, 6'b001101, 6'b000101, 0, 0, 0, 1));
        vecs.push_back(mk(32'h1000_0000, 5, 6'b010000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'hFFFF_F800, 2, 6'b100000, 6'b000000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h7FFF_FFFF, 6, 6'b000001, 6'b111111, 6'b111111, 6'b111111,
                          6'b111111, 6'b111111, 0));

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_chunk", {26'd0, out_chunk}, 32'd0);
        chk("rst_out_first", {31'd0, out_first}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_count", {29'd0, out_count}, 32'd0);

        foreach (vecs[i]) run_value(vecs[i].value, vecs[i].n, vecs[i].ch, 1'b1, vecs[i].mode);

        // Reset after the first chunk of a six-chunk value
        in_valid = 1'b1; in_value = 32'h7FFF_FFFF;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        chk("mid_first_chunk", {26'd0, out_chunk}, 32'd1);
        @(negedge clk);
        out_ready = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_chunk", {26'd0, out_chunk}, 32'd0);
        chk("mid_rst_flags", {30'd0, out_first, out_last}, 32'd0);
        chk("mid_rst_count", {29'd0, out_count}, 32'd0);
        none[0] = 6'b000011;
        run_value(32'h0000_0003, 1, none, 1'b1, 0);

        for (int i = 0; i < 1000; i++) begin
            rv = $urandom;
            rv = $signed(rv) >>> $urandom_range(0, 31);
            run_value(rv, model_n(rv), none, 1'b0, 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
